// File: rtl/sram_pkg.sv
// Shared types and defaults for the 32-bit CPU to 16-bit async SRAM bridge.
// No logic here; latency and freeze behaviour are defined by sram_controller.
package sram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      WR_LO,
      WR_HI,
      DONE
   } state_t;

   localparam int unsigned ACCESS_CYCLES_DEF = 2;
   localparam logic [31:0] ADDR_BASE_DEF     = 32'd1024;

endpackage

// File: rtl/sram_controller_if.sv
// Memory-stage request/response bundle between the CPU pipeline and the SRAM bridge.
// ready is the only flow control: the pipeline freezes while it is low.
interface sram_controller_if;

   logic        rdEn;
   logic        wrEn;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        ready;

   modport master (output rdEn, wrEn, address, writeData, input readData, ready);
   modport slave  (input rdEn, wrEn, address, writeData, output readData, ready);

endinterface

// File: rtl/sram_controller_register.sv
// Loadable register with synchronous clear; one-cycle load latency.
// Holds its value whenever ld is low, no backpressure.
module sram_controller_register #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] data_q, data_d;

   always_comb begin
      data_d = data_q;
      if (clr)
         data_d = '0;
      else if (ld)
         data_d = d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         data_q <= '0;
      else
         data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit async SRAM accesses (low half at even address).
// ready stays low for 1+2*ACCESS_CYCLES cycles per request, then pulses high for the DONE cycle.
module sram_controller
   import sram_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF,
   parameter logic [31:0] ADDR_BASE     = ADDR_BASE_DEF
) (
   input  logic                clk,
   input  logic                rst,
   sram_controller_if.slave    cpu,
   output logic [17:0]         sramAddr,
   output logic [15:0]         sramDqOut,
   output logic                sramDqOe,
   input  logic [15:0]         sramDqIn,
   output logic                sramWeN,
   output logic                sramOeN,
   output logic                sramCeN,
   output logic                sramUbN,
   output logic                sramLbN
);

   localparam logic [3:0] LAST_CNT    = 4'(ACCESS_CYCLES - 1);
   localparam logic       WE_WHOLE_ST = (ACCESS_CYCLES == 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [16:0] word_q, word_d;
   logic [31:0] wdata_q, wdata_d;

   logic [31:0] offset;
   logic        req;
   logic        last;
   logic        ld_lo, ld_hi;
   logic [15:0] rd_lo, rd_hi;
   logic        unused_offset_bits;

   assign offset             = cpu.address - ADDR_BASE;
   assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
   assign req                = cpu.rdEn | cpu.wrEn;
   assign last               = (cnt_q == LAST_CNT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               word_d  = offset[18:2];
               wdata_d = cpu.writeData;
               cnt_d   = '0;
               state_d = cpu.wrEn ? WR_LO : RD_LO;
            end
         end
         RD_LO, RD_HI, WR_LO, WR_HI: begin
            if (last) begin
               cnt_d = '0;
               case (state_q)
                  RD_LO:   state_d = RD_HI;
                  WR_LO:   state_d = WR_HI;
                  default: state_d = DONE;
               endcase
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
      end
   end

   // Pad outputs decode straight from state so reset forces them inactive at once.
   always_comb begin
      sramAddr  = '0;
      sramDqOut = '0;
      sramDqOe  = 1'b0;
      sramWeN   = 1'b1;
      sramOeN   = 1'b1;
      sramCeN   = 1'b1;
      cpu.ready = 1'b0;
      case (state_q)
         IDLE: cpu.ready = ~req;
         DONE: cpu.ready = 1'b1;
         RD_LO, RD_HI: begin
            sramCeN  = 1'b0;
            sramOeN  = 1'b0;
            sramAddr = {word_q, state_q == RD_HI};
         end
         WR_LO, WR_HI: begin
            sramCeN   = 1'b0;
            sramDqOe  = 1'b1;
            sramAddr  = {word_q, state_q == WR_HI};
            sramDqOut = (state_q == WR_HI) ? wdata_q[31:16] : wdata_q[15:0];
            // Release WE one cycle early so data is stable at the WE rising edge.
            sramWeN   = ~(WE_WHOLE_ST | ~last);
         end
         default: ;
      endcase
   end

   assign sramUbN = 1'b0;
   assign sramLbN = 1'b0;

   assign ld_lo = (state_q == RD_LO) && last;
   assign ld_hi = (state_q == RD_HI) && last;

   sram_controller_register #(.W(16)) u_rd_lo (
      .clk (clk),
      .rst (rst),
      .ld  (ld_lo),
      .clr (1'b0),
      .d   (sramDqIn),
      .q   (rd_lo)
   );

   sram_controller_register #(.W(16)) u_rd_hi (
      .clk (clk),
      .rst (rst),
      .ld  (ld_hi),
      .clr (1'b0),
      .d   (sramDqIn),
      .q   (rd_hi)
   );

   assign cpu.readData = {rd_hi, rd_lo};

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: default-timing controller against a small SRAM model, plus a
// single-cycle-access instance reading a fixed table for back-to-back reads.
module tb_sram_controller;

   logic clk;
   logic rst;

   sram_controller_if cpu ();
   sram_controller_if cpu1 ();

   logic [17:0] s_addr, s_addr1;
   logic [15:0] dq_out, dq_out1, dq_in, dq_in1;
   logic        dq_oe, dq_oe1, we_n, we_n1, oe_n, oe_n1, ce_n, ce_n1;
   logic        ub_n, lb_n, ub_n1, lb_n1;

   logic [15:0] mem  [64];
   logic [15:0] rom1 [4];

   int n_checks;
   int n_pass;

   logic [5:0]  ready_v, wen_v, oen_v, dqoe_v;
   logic [17:0] addr_s [6];
   logic [15:0] dq_s   [6];
   logic [31:0] rd_s   [6];
   logic [7:0]  ready1_v;
   logic [31:0] rd1_c3, rd1_c7;

   sram_controller dut (
      .clk(clk), .rst(rst), .cpu(cpu),
      .sramAddr(s_addr), .sramDqOut(dq_out), .sramDqOe(dq_oe), .sramDqIn(dq_in),
      .sramWeN(we_n), .sramOeN(oe_n), .sramCeN(ce_n), .sramUbN(ub_n), .sramLbN(lb_n)
   );

   sram_controller #(.ACCESS_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .cpu(cpu1),
      .sramAddr(s_addr1), .sramDqOut(dq_out1), .sramDqOe(dq_oe1), .sramDqIn(dq_in1),
      .sramWeN(we_n1), .sramOeN(oe_n1), .sramCeN(ce_n1), .sramUbN(ub_n1), .sramLbN(lb_n1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (!ce_n && !we_n) mem[s_addr[5:0]] <= dq_out;

   assign dq_in  = (!ce_n && !oe_n) ? mem[s_addr[5:0]] : 16'h0;
   assign dq_in1 = (!ce_n1 && !oe_n1) ? rom1[s_addr1[1:0]] : 16'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // One request on the default instance; samples six cycles (IDLE, 2x LO, 2x HI, DONE).
   task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input bit drop_mid);
      @(posedge clk); #1;
      cpu.rdEn = rd; cpu.wrEn = wr; cpu.address = a; cpu.writeData = wd;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         ready_v[k] = cpu.ready;
         wen_v[k]   = we_n;
         oen_v[k]   = oe_n;
         dqoe_v[k]  = dq_oe;
         addr_s[k]  = s_addr;
         dq_s[k]    = dq_out;
         rd_s[k]    = cpu.readData;
         if (drop_mid && k == 1) begin
            cpu.rdEn = 1'b0; cpu.wrEn = 1'b0; cpu.address = 32'hFFFF_FFFC;
         end
      end
      cpu.rdEn = 1'b0; cpu.wrEn = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rom1[0] = 16'h1111; rom1[1] = 16'h2222; rom1[2] = 16'h3333; rom1[3] = 16'h4444;
      cpu.rdEn = 0; cpu.wrEn = 0; cpu.address = 0; cpu.writeData = 0;
      cpu1.rdEn = 0; cpu1.wrEn = 0; cpu1.address = 0; cpu1.writeData = 0;
      rst = 1'b0;
      #22;
      check("rst_ready",    {31'd0, cpu.ready}, 32'd1);
      check("rst_readData", cpu.readData, 32'h0);
      check("rst_strobes",  {29'd0, we_n, oe_n, ce_n}, 32'h7);
      check("rst_dqoe",     {31'd0, dq_oe}, 32'd0);
      check("rst_addr",     {14'd0, s_addr}, 32'd0);
      @(negedge clk); rst = 1'b1;

      // Store 0xDEADBEEF at the base address.
      run_op(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0);
      check("wr_ready",   {26'd0, ready_v}, 32'h20);
      check("wr_wen",     {26'd0, wen_v},   32'h35);
      check("wr_dqoe",    {26'd0, dqoe_v},  32'h1E);
      check("wr_addr_lo", {14'd0, addr_s[1]}, 32'd0);
      check("wr_addr_hi", {14'd0, addr_s[3]}, 32'd1);
      check("wr_dq_lo",   {16'd0, dq_s[1]}, 32'hBEEF);
      check("wr_dq_hi",   {16'd0, dq_s[3]}, 32'hDEAD);
      check("wr_mem",     {mem[1], mem[0]}, 32'hDEAD_BEEF);
      check("wr_rd_hold", rd_s[5], 32'h0);

      // Load it back.
      run_op(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
      check("rd_ready",   {26'd0, ready_v}, 32'h20);
      check("rd_dqoe",    {26'd0, dqoe_v},  32'h0);
      check("rd_oen",     {26'd0, oen_v},   32'h21);
      check("rd_wen",     {26'd0, wen_v},   32'h3F);
      check("rd_half",    rd_s[3], 32'h0000_BEEF);
      check("rd_done",    rd_s[5], 32'hDEAD_BEEF);

      // Both requests at once: the write wins, no read sample.
      run_op(1'b1, 1'b1, 32'd1032, 32'h1234_5678, 1'b0);
      check("both_addr_lo", {14'd0, addr_s[1]}, 32'd4);
      check("both_addr_hi", {14'd0, addr_s[3]}, 32'd5);
      check("both_oen",     {26'd0, oen_v}, 32'h3F);
      check("both_mem",     {mem[5], mem[4]}, 32'h1234_5678);
      check("both_rd_hold", rd_s[5], 32'hDEAD_BEEF);

      // Request dropped and address changed mid-operation still completes.
      run_op(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1);
      check("drop_ready", {26'd0, ready_v}, 32'h20);
      check("drop_data",  rd_s[5], 32'h1234_5678);
      @(negedge clk);
      check("drop_idle",  {31'd0, cpu.ready}, 32'd1);

      // Reset during the second WR_HI cycle.
      @(posedge clk); #1;
      cpu.wrEn = 1'b1; cpu.address = 32'd1024; cpu.writeData = 32'hCAFE_F00D;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("arst_wen",  {31'd0, we_n},  32'd1);
      check("arst_dqoe", {31'd0, dq_oe}, 32'd0);
      check("arst_ce",   {31'd0, ce_n},  32'd1);
      check("arst_addr", {14'd0, s_addr}, 32'd0);
      check("arst_rd",   cpu.readData, 32'h0);
      cpu.wrEn = 1'b0;
      #1;
      check("arst_idle", {31'd0, cpu.ready}, 32'd1);
      @(negedge clk); rst = 1'b1;

      // Fresh access after reset; the interrupted store had written both halves.
      run_op(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
      check("post_rst_ready", {26'd0, ready_v}, 32'h20);
      check("post_rst_data",  rd_s[5], 32'hCAFE_F00D);

      // Single-cycle accesses, back-to-back reads.
      @(posedge clk); #1;
      cpu1.rdEn = 1'b1; cpu1.address = 32'd1024;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         ready1_v[c] = cpu1.ready;
         if (c == 3) begin
            rd1_c3 = cpu1.readData;
            cpu1.address = 32'd1028;
         end
         if (c == 7) rd1_c7 = cpu1.readData;
      end
      cpu1.rdEn = 1'b0;
      check("b2b_ready", {24'd0, ready1_v}, 32'h88);
      check("b2b_rd0",   rd1_c3, 32'h2222_1111);
      check("b2b_rd1",   rd1_c7, 32'h4444_3333);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
